// File: rtl/rx_hs_clk_monitor.sv
// Monitors N_LANES HS clock lanes: settle, recover clock, flag clock misses.
// Optional per-lane edge counter enabled by defining RX_HS_CLK_EDGE_COUNT_EN.
module rx_hs_clk_monitor #(
  parameter int unsigned N_LANES = 2,
  parameter int unsigned TMR_W   = 8,
  parameter int unsigned TSETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_LANES-1:0]     hs_enable_i,
  input  logic [N_LANES-1:0]     clkdp_i,
  input  logic [N_LANES-1:0]     clkdn_i,
  input  logic [TMR_W-1:0]       tclk_miss_i,
  input  logic                   err_clr_i,
  output logic [N_LANES-1:0]     rx_hs_clk_o,
  output logic [N_LANES-1:0]     clk_active_o,
  output logic [N_LANES-1:0]     miss_err_o,
  output logic [16*N_LANES-1:0]  edge_cnt_o
);

  localparam logic [1:0] StStop   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
  localparam logic [1:0] StEnd    = 2'd3;

  localparam int unsigned SetW = (TSETTLE > 1) ? $clog2(TSETTLE) : 1;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [1:0]       state_q, state_d;
    logic [SetW-1:0]  settle_q, settle_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             clkdp_q;
    logic             edge_det;
    logic             timeout;
    logic             miss_q, miss_d;
    logic             active_q;

    assign edge_det = clkdp_i[i] ^ clkdp_q;

    always_comb begin
      state_d  = state_q;
      settle_d = '0;
      timer_d  = '0;
      timeout  = 1'b0;
      case (state_q)
        StStop: begin
          if (hs_enable_i[i]) state_d = StSettle;
        end
        StSettle: begin
          if (settle_q == SetW'(TSETTLE - 1)) state_d = StActive;
          else settle_d = settle_q + 1'b1;
        end
        StActive: begin
          if (!edge_det) timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
          // Compare the updated timer so the Nth edgeless cycle trips at threshold N.
          if ((tclk_miss_i != '0) && (timer_d >= tclk_miss_i)) begin
            timeout = 1'b1;
            state_d = StEnd;
          end
        end
        StEnd: begin
          if (clkdp_i[i] && clkdn_i[i]) state_d = StStop;
        end
        default: state_d = StStop;
      endcase
      // Disable overrides every transition, including a pending timeout.
      if (!hs_enable_i[i]) begin
        state_d = StStop;
        timeout = 1'b0;
      end
    end

    // Set wins over a same-cycle clear.
    assign miss_d = (miss_q & ~err_clr_i) | timeout;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= StStop;
        settle_q <= '0;
        timer_q  <= '0;
        clkdp_q  <= 1'b0;
        miss_q   <= 1'b0;
        active_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        settle_q <= settle_d;
        timer_q  <= timer_d;
        clkdp_q  <= clkdp_i[i];
        miss_q   <= miss_d;
        active_q <= (state_d == StActive);
      end
    end

    assign rx_hs_clk_o[i]  = (state_q == StActive) & clkdp_i[i];
    assign clk_active_o[i] = active_q;
    assign miss_err_o[i]   = miss_q;

`ifdef RX_HS_CLK_EDGE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if ((state_q != StSettle) && (state_d == StSettle)) begin
        cnt_d = '0;
      end else if ((state_q == StActive) && edge_det && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign edge_cnt_o[16*i +: 16] = cnt_q;
`else
    assign edge_cnt_o[16*i +: 16] = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_rx_hs_clk_monitor.sv
// Directed self-checking bench for rx_hs_clk_monitor (2 lanes, TMR_W=8, TSETTLE=4).
module tb_rx_hs_clk_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hs_enable, clkdp, clkdn, tog;
  logic [7:0]  tclk_miss;
  logic        err_clr;
  logic [1:0]  rx_hs_clk, clk_active, miss_err;
  logic [31:0] edge_cnt;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt;

  rx_hs_clk_monitor #(
    .N_LANES (2),
    .TMR_W   (8),
    .TSETTLE (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .hs_enable_i  (hs_enable),
    .clkdp_i      (clkdp),
    .clkdn_i      (clkdn),
    .tclk_miss_i  (tclk_miss),
    .err_clr_i    (err_clr),
    .rx_hs_clk_o  (rx_hs_clk),
    .clk_active_o (clk_active),
    .miss_err_o   (miss_err),
    .edge_cnt_o   (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then toggle the lanes flagged in tog.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog[0]) clkdp[0] = ~clkdp[0];
    if (tog[1]) clkdp[1] = ~clkdp[1];
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1; hs_enable = '0; clkdp = 2'b11; clkdn = '0; tog = '0;
    tclk_miss = '0; err_clr = 1'b0;
    ticks(2);
    check("rst_active", {30'd0, clk_active}, 32'd0);
    check("rst_miss", {30'd0, miss_err}, 32'd0);
    check("rst_rxclk", {30'd0, rx_hs_clk}, 32'd0);
    check("rst_edgecnt", edge_cnt, 32'd0);
    @(posedge clk); #1; rst = 1'b0; #1;
    check("post_rst_rxclk", {30'd0, rx_hs_clk}, 32'd0);
    clkdp = 2'b00;
    tick();

    // Lane 0 bring-up with a clock toggling every cycle.
    hs_enable[0] = 1'b1; tog[0] = 1'b1;
    ticks(4);
    check("l0_settling", {31'd0, clk_active[0]}, 32'd0);
    tick();
    check("l0_active_5cyc", {31'd0, clk_active[0]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("l0_rxclk_follow", {31'd0, rx_hs_clk[0]}, {31'd0, clkdp[0]});
      tick();
    end
    check("l0_no_miss", {30'd0, miss_err}, 32'd0);
    check("l1_idle", {31'd0, clk_active[1]}, 32'd0);

    // Lane 1 with a stuck clock times out after 10 edgeless ACTIVE cycles.
    tclk_miss = 8'd10; hs_enable[1] = 1'b1;
    ticks(5);
    check("l1_active", {31'd0, clk_active[1]}, 32'd1);
    ticks(9);
    check("l1_pre_timeout_act", {31'd0, clk_active[1]}, 32'd1);
    check("l1_pre_timeout_miss", {31'd0, miss_err[1]}, 32'd0);
    tick();
    check("l1_timeout_act", {31'd0, clk_active[1]}, 32'd0);
    check("l1_timeout_miss", {30'd0, miss_err}, 32'd2);
    check("l0_unaffected", {31'd0, clk_active[0]}, 32'd1);

    // LP-11 in END returns to STOP, then SETTLE again while enabled.
    clkdp[1] = 1'b1; clkdn[1] = 1'b1;
    ticks(5);
    check("l1_resettle_act", {31'd0, clk_active[1]}, 32'd0);
    check("l1_settle_rxclk", {31'd0, rx_hs_clk[1]}, 32'd0);
    tick();
    check("l1_reactive", {31'd0, clk_active[1]}, 32'd1);
    check("l1_active_rxclk", {31'd0, rx_hs_clk[1]}, 32'd1);
    check("l1_miss_sticky", {31'd0, miss_err[1]}, 32'd1);
    hs_enable[1] = 1'b0; clkdp[1] = 1'b0; clkdn[1] = 1'b0;
    tick();
    check("l1_disable_act", {31'd0, clk_active[1]}, 32'd0);
    check("l1_disable_miss", {31'd0, miss_err[1]}, 32'd1);

    // Lane 0 timeout coincident with err_clr: lane 0 set wins, lane 1 cleared.
    tog[0] = 1'b0;
    ticks(10);
    check("clr_pre_miss", {30'd0, miss_err}, 32'd2);
    check("clr_pre_act0", {31'd0, clk_active[0]}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_set_wins", {30'd0, miss_err}, 32'd1);
    check("clr_l0_end", {31'd0, clk_active[0]}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_alone", {30'd0, miss_err}, 32'd0);

    // tclk_miss=0: no timeout; timer saturates so threshold 255 trips at once.
    tclk_miss = 8'd0; clkdp[0] = 1'b1; clkdn[0] = 1'b1;
    ticks(6);
    check("sat_active", {31'd0, clk_active[0]}, 32'd1);
    ticks(300);
    check("sat_still_active", {31'd0, clk_active[0]}, 32'd1);
    check("sat_no_miss", {30'd0, miss_err}, 32'd0);
    tclk_miss = 8'd255;
    tick();
    check("sat_timeout_miss", {30'd0, miss_err}, 32'd1);
    check("sat_timeout_act", {31'd0, clk_active[0]}, 32'd0);

    // 20 edges in ACTIVE.
    tclk_miss = 8'd0;
    ticks(6);
    check("cnt_active", {31'd0, clk_active[0]}, 32'd1);
    clkdp[0] = ~clkdp[0]; tog[0] = 1'b1;
    ticks(19);
    tog[0] = 1'b0;
    tick();
`ifdef RX_HS_CLK_EDGE_COUNT_EN
    exp_cnt = 32'd20;
`else
    exp_cnt = 32'd0;
`endif
    check("cnt_lane0", {16'd0, edge_cnt[15:0]}, exp_cnt);
    check("cnt_lane1", {16'd0, edge_cnt[31:16]}, 32'd0);

    // Asynchronous reset in the middle of ACTIVE.
    clkdp[0] = 1'b1; #1;
    check("pre_rst_rxclk", {30'd0, rx_hs_clk}, 32'd1);
    rst = 1'b1; #1;
    check("async_rst_act", {30'd0, clk_active}, 32'd0);
    check("async_rst_rxclk", {30'd0, rx_hs_clk}, 32'd0);
    check("async_rst_miss", {30'd0, miss_err}, 32'd0);
    check("async_rst_cnt", edge_cnt, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_abort_act", {30'd0, clk_active}, 32'd0);
    check("post_abort_miss", {30'd0, miss_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
